// File: rtl/patch_reducer_scheduler_pkg.sv
// Shared definitions for the patch reducer scheduler.
// Provides the ceiling-log2 helper used to size reducer IDs, FIFO pointers
// and occupancy counts, plus the default geometry of the pool.
package patch_reducer_scheduler_pkg;

  localparam int unsigned DEFAULT_N_REDUCER  = 4;
  localparam int unsigned DEFAULT_N_ROW_SIZE = 11;
  localparam int unsigned DEFAULT_FP_SIZE    = 32;

  // Smallest r with 2**r >= value; used at elaboration time only.
  function automatic int unsigned log2_ceil(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/patch_reducer_scheduler_order_fifo.sv
// reducer_order_fifo: register-based synchronous FIFO that remembers the
// order in which patches were handed to reducers.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   push, push_id/row   enqueue {reducer ID, start row}
//   pop                 dequeue the head entry (caller guarantees non-empty)
//   head_id, head_row   oldest entry
//   count               current occupancy (0..DEPTH)
module reducer_order_fifo
  import patch_reducer_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_N_REDUCER,
  parameter int unsigned ID_W  = log2_ceil(DEFAULT_N_REDUCER),
  parameter int unsigned ROW_W = DEFAULT_N_ROW_SIZE
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  logic [ID_W-1:0]                  push_id,
  input  logic [ROW_W-1:0]                 push_row,
  input  logic                             pop,
  output logic [ID_W-1:0]                  head_id,
  output logic [ROW_W-1:0]                 head_row,
  output logic [log2_ceil(DEPTH+1)-1:0]    count
);

  localparam int unsigned PTR_W = log2_ceil(DEPTH);
  localparam int unsigned CNT_W = log2_ceil(DEPTH + 1);

  logic [ID_W-1:0]  id_mem  [DEPTH];
  logic [ROW_W-1:0] row_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointer increment with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign head_id  = id_mem[rd_ptr];
  assign head_row = row_mem[rd_ptr];

  // Storage, pointers and occupancy; push+pop together leave count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        id_mem[i]  <= '0;
        row_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        id_mem[wr_ptr]  <= push_id;
        row_mem[wr_ptr] <= push_row;
        wr_ptr          <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/patch_reducer_scheduler.sv
// patch_reducer_scheduler: hands patch requests to a pool of reducers and
// returns their sums strictly in request order.
// Ports:
//   dram_clk, reset                 clock, asynchronous active-high reset
//   patch_valid/start_row/ack       request in; ack is combinational
//   red_init, red_start_row         one-hot init pulse and row to a reducer
//   red_sum_rdy, red_sum            per-reducer finished flag and flat sums
//   red_sum_ack                     one-hot release pulse to a reducer
//   sum_valid/sum/sum_row/sum_ready result register toward the consumer
//   idle                            pool free and result register empty
module patch_reducer_scheduler
  import patch_reducer_scheduler_pkg::*;
#(
  parameter int unsigned N_REDUCER  = DEFAULT_N_REDUCER,
  parameter int unsigned N_ROW_SIZE = DEFAULT_N_ROW_SIZE,
  parameter int unsigned FP_SIZE    = DEFAULT_FP_SIZE
) (
  input  logic                           dram_clk,
  input  logic                           reset,
  input  logic                           patch_valid,
  input  logic [N_ROW_SIZE-1:0]          patch_start_row,
  output logic                           patch_ack,
  output logic [N_REDUCER-1:0]           red_init,
  output logic [N_ROW_SIZE-1:0]          red_start_row,
  input  logic [N_REDUCER-1:0]           red_sum_rdy,
  input  logic [N_REDUCER*FP_SIZE-1:0]   red_sum,
  output logic [N_REDUCER-1:0]           red_sum_ack,
  output logic                           sum_valid,
  output logic [FP_SIZE-1:0]             sum,
  output logic [N_ROW_SIZE-1:0]          sum_row,
  input  logic                           sum_ready,
  output logic                           idle
);

  localparam int unsigned ID_W  = log2_ceil(N_REDUCER);
  localparam int unsigned CNT_W = log2_ceil(N_REDUCER + 1);

  logic [N_REDUCER-1:0]  free;
  logic [ID_W-1:0]       alloc_id;
  logic [N_REDUCER-1:0]  alloc_mask;
  logic [N_REDUCER-1:0]  release_mask;
  logic [ID_W-1:0]       head_id;
  logic [N_ROW_SIZE-1:0] head_row;
  logic [CNT_W-1:0]      fifo_count;
  logic                  head_rdy;
  logic [FP_SIZE-1:0]    head_sum;
  logic                  capture;

  // Lowest-index set bit of the free mask.
  function automatic logic [ID_W-1:0] lowest_free(input logic [N_REDUCER-1:0] mask);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = int'(N_REDUCER) - 1; i >= 0; i--) begin
      if (mask[i]) id = ID_W'(i);
    end
    return id;
  endfunction

  // Allocation looks only at the pre-edge free mask, so a reducer being
  // released this cycle cannot be reassigned until the following cycle.
  assign patch_ack  = patch_valid && (free != '0) && !reset;
  assign alloc_id   = lowest_free(free);
  assign alloc_mask = patch_ack ? (N_REDUCER'(1) << alloc_id) : '0;

  // Only the FIFO head is ever examined; a ready non-head or free reducer waits.
  always_comb begin
    head_rdy = 1'b0;
    head_sum = '0;
    for (int i = 0; i < int'(N_REDUCER); i++) begin
      if (head_id == ID_W'(i)) begin
        head_rdy = red_sum_rdy[i];
        head_sum = red_sum[i*FP_SIZE +: FP_SIZE];
      end
    end
  end

  assign capture      = (fifo_count != '0) && head_rdy && (!sum_valid || sum_ready);
  assign release_mask = capture ? (N_REDUCER'(1) << head_id) : '0;
  assign idle         = (&free) && !sum_valid;

  reducer_order_fifo #(
    .DEPTH (N_REDUCER),
    .ID_W  (ID_W),
    .ROW_W (N_ROW_SIZE)
  ) u_order_fifo (
    .clk      (dram_clk),
    .reset    (reset),
    .push     (patch_ack),
    .push_id  (alloc_id),
    .push_row (patch_start_row),
    .pop      (capture),
    .head_id  (head_id),
    .head_row (head_row),
    .count    (fifo_count)
  );

  // Pool bookkeeping, one-cycle reducer pulses and the output register.
  always_ff @(posedge dram_clk or posedge reset) begin
    if (reset) begin
      free          <= '1;
      red_init      <= '0;
      red_sum_ack   <= '0;
      red_start_row <= '0;
      sum_valid     <= 1'b0;
      sum           <= '0;
      sum_row       <= '0;
    end else begin
      free        <= (free & ~alloc_mask) | release_mask;
      red_init    <= alloc_mask;
      red_sum_ack <= release_mask;
      if (patch_ack) begin
        red_start_row <= patch_start_row;
      end
      if (capture) begin
        sum       <= head_sum;
        sum_row   <= head_row;
        sum_valid <= 1'b1;
      end else if (sum_ready) begin
        sum_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_patch_reducer_scheduler.sv
// Self-checking bench for patch_reducer_scheduler: table-driven single-patch
// vectors plus hand-written multi-cycle sequences, with a scoreboard queue of
// expected {row, sum} results filled at acceptance and drained on handshake.
module tb_patch_reducer_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned RW = 11;
  localparam int unsigned FW = 32;

  logic              dram_clk = 1'b0;
  logic              reset;
  logic              patch_valid;
  logic [RW-1:0]     patch_start_row;
  logic              patch_ack;
  logic [N-1:0]      red_init;
  logic [RW-1:0]     red_start_row;
  logic [N-1:0]      red_sum_rdy;
  logic [N*FW-1:0]   red_sum;
  logic [N-1:0]      red_sum_ack;
  logic              sum_valid;
  logic [FW-1:0]     sum;
  logic [RW-1:0]     sum_row;
  logic              sum_ready;
  logic              idle;

  typedef struct packed {
    logic [RW-1:0] row;
    logic [FW-1:0] val;
  } exp_t;

  typedef struct {
    logic [RW-1:0] row;
    logic [FW-1:0] val;
    int            exp_id;
  } vec_t;

  exp_t          exp_q[$];
  logic [FW-1:0] plan_sum [N];
  vec_t          vecs [3];
  int            n_cmp = 0;
  int            n_bad = 0;

  patch_reducer_scheduler #(
    .N_REDUCER  (N),
    .N_ROW_SIZE (RW),
    .FP_SIZE    (FW)
  ) dut (
    .dram_clk        (dram_clk),
    .reset           (reset),
    .patch_valid     (patch_valid),
    .patch_start_row (patch_start_row),
    .patch_ack       (patch_ack),
    .red_init        (red_init),
    .red_start_row   (red_start_row),
    .red_sum_rdy     (red_sum_rdy),
    .red_sum         (red_sum),
    .red_sum_ack     (red_sum_ack),
    .sum_valid       (sum_valid),
    .sum             (sum),
    .sum_row         (sum_row),
    .sum_ready       (sum_ready),
    .idle            (idle)
  );

  always #5 dram_clk = ~dram_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: score the output handshake before the edge, then check the
  // reducer pulses just after it and drop rdy for any acked reducer.
  task automatic tick();
    logic [N-1:0] rdy_snap;
    exp_t         e;
    @(negedge dram_clk);
    rdy_snap = red_sum_rdy;
    if (sum_valid && sum_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got row %0d with nothing expected", sum_row);
      end else begin
        e = exp_q.pop_front();
        check("sb_sum", 64'(sum), 64'(e.val));
        check("sb_row", 64'(sum_row), 64'(e.row));
      end
    end
    @(posedge dram_clk);
    #1;
    check("ack_without_rdy", 64'(red_sum_ack & ~rdy_snap), 64'(0));
    check("init_ack_overlap", 64'(red_init & red_sum_ack), 64'(0));
    red_sum_rdy = red_sum_rdy & ~red_sum_ack;
  endtask

  task automatic request(input logic [RW-1:0] row, input logic [FW-1:0] val, input int exp_id);
    patch_valid     = 1'b1;
    patch_start_row = row;
    #1;
    check("patch_ack", 64'(patch_ack), 64'(1));
    if (patch_ack) begin
      exp_q.push_back({row, val});
      plan_sum[exp_id] = val;
    end
    tick();
    patch_valid = 1'b0;
    check("red_init", 64'(red_init), 64'(N'(1) << exp_id));
    check("red_start_row", 64'(red_start_row), 64'(row));
  endtask

  task automatic finish_red(input int id);
    red_sum[id*FW +: FW] = plan_sum[id];
    red_sum_rdy[id]      = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!idle && n < budget) begin
      tick();
      n++;
    end
    check("idle_reached", 64'(idle), 64'(1));
  endtask

  initial begin
    vecs[0] = '{11'd100,  32'h4020_0000, 0};
    vecs[1] = '{11'd7,    32'h3f80_0000, 0};
    vecs[2] = '{11'd2047, 32'hc000_0000, 0};

    reset           = 1'b0;
    patch_valid     = 1'b0;
    patch_start_row = '0;
    red_sum_rdy     = '0;
    red_sum         = '0;
    sum_ready       = 1'b1;
    for (int i = 0; i < int'(N); i++) plan_sum[i] = '0;

    // Reset state
    #1 reset = 1'b1;
    #1;
    check("rst_sum_valid", 64'(sum_valid), 64'(0));
    check("rst_red_init", 64'(red_init), 64'(0));
    check("rst_red_sum_ack", 64'(red_sum_ack), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_sum_row", 64'(sum_row), 64'(0));
    check("rst_red_start_row", 64'(red_start_row), 64'(0));
    check("rst_idle", 64'(idle), 64'(1));
    @(posedge dram_clk);
    @(posedge dram_clk);
    #1 reset = 1'b0;

    // Single patches from the vector table
    for (int k = 0; k < 3; k++) begin
      request(vecs[k].row, vecs[k].val, vecs[k].exp_id);
      finish_red(vecs[k].exp_id);
      tick();
      check("single_init_cleared", 64'(red_init), 64'(0));
      check("single_sum_valid", 64'(sum_valid), 64'(1));
      check("single_sum", 64'(sum), 64'(vecs[k].val));
      check("single_sum_row", 64'(sum_row), 64'(vecs[k].row));
      check("single_ack", 64'(red_sum_ack), 64'(N'(1) << vecs[k].exp_id));
      check("single_not_idle", 64'(idle), 64'(0));
      tick();
      check("single_valid_clear", 64'(sum_valid), 64'(0));
      check("single_ack_clear", 64'(red_sum_ack), 64'(0));
      check("single_idle", 64'(idle), 64'(1));
    end

    // Pool exhaustion and re-use of the released reducer
    for (int k = 0; k < 4; k++) request(RW'(8 * k), 32'h3f80_0010 + FW'(k), k);
    patch_valid     = 1'b1;
    patch_start_row = 11'd32;
    #1;
    check("full_no_ack", 64'(patch_ack), 64'(0));
    tick();
    check("full_no_init", 64'(red_init), 64'(0));
    check("full_no_ack2", 64'(patch_ack), 64'(0));
    finish_red(0);
    #1;
    check("full_no_ack3", 64'(patch_ack), 64'(0));
    tick();
    check("full_ack0", 64'(red_sum_ack), 64'(1));
    check("full_no_init_on_ack", 64'(red_init), 64'(0));
    check("full_accept_after_release", 64'(patch_ack), 64'(1));
    if (patch_ack) begin
      exp_q.push_back({11'd32, 32'h3f80_0020});
      plan_sum[0] = 32'h3f80_0020;
    end
    tick();
    patch_valid = 1'b0;
    check("full_reinit0", 64'(red_init), 64'(1));
    check("full_reinit_row", 64'(red_start_row), 64'(32));
    finish_red(1); finish_red(2); finish_red(3); finish_red(0);
    wait_idle(30);

    // Out-of-order completion
    request(11'd200, 32'h4100_0000, 0);
    request(11'd201, 32'h4100_0001, 1);
    request(11'd202, 32'h4100_0002, 2);
    finish_red(2);
    tick(); check("ooo_hold_a", 64'(red_sum_ack), 64'(0));
    check("ooo_no_valid", 64'(sum_valid), 64'(0));
    tick(); check("ooo_hold_b", 64'(red_sum_ack), 64'(0));
    finish_red(1);
    tick(); check("ooo_hold_c", 64'(red_sum_ack), 64'(0));
    finish_red(0);
    tick(); check("ooo_ack0", 64'(red_sum_ack), 64'(4'b0001));
    tick(); check("ooo_ack1", 64'(red_sum_ack), 64'(4'b0010));
    tick(); check("ooo_ack2", 64'(red_sum_ack), 64'(4'b0100));
    wait_idle(10);

    // Backpressure then bubble-free reload
    sum_ready = 1'b0;
    request(11'd300, 32'h4200_0000, 0);
    request(11'd301, 32'h4200_0001, 1);
    finish_red(0);
    finish_red(1);
    tick();
    check("bp_ack0", 64'(red_sum_ack), 64'(4'b0001));
    check("bp_valid", 64'(sum_valid), 64'(1));
    for (int c = 0; c < 10; c++) begin
      tick();
      check("bp_sum_stable", 64'(sum), 64'(32'h4200_0000));
      check("bp_row_stable", 64'(sum_row), 64'(300));
      check("bp_no_ack", 64'(red_sum_ack), 64'(0));
    end
    sum_ready = 1'b1;
    tick();
    check("bp_reload_valid", 64'(sum_valid), 64'(1));
    check("bp_reload_sum", 64'(sum), 64'(32'h4200_0001));
    check("bp_reload_row", 64'(sum_row), 64'(301));
    check("bp_reload_ack1", 64'(red_sum_ack), 64'(4'b0010));
    tick();
    check("bp_drained", 64'(sum_valid), 64'(0));
    wait_idle(10);

    // Simultaneous release of reducer 0 and request with reducer 3 free
    request(11'd400, 32'h4300_0000, 0);
    request(11'd401, 32'h4300_0001, 1);
    request(11'd402, 32'h4300_0002, 2);
    finish_red(0);
    patch_valid     = 1'b1;
    patch_start_row = 11'd403;
    #1;
    check("simul_ack", 64'(patch_ack), 64'(1));
    if (patch_ack) begin
      exp_q.push_back({11'd403, 32'h4300_0003});
      plan_sum[3] = 32'h4300_0003;
    end
    tick();
    patch_valid = 1'b0;
    check("simul_init3", 64'(red_init), 64'(4'b1000));
    check("simul_ack0", 64'(red_sum_ack), 64'(4'b0001));
    check("simul_row", 64'(red_start_row), 64'(403));
    check("simul_fifo_count", 64'(dut.fifo_count), 64'(3));
    finish_red(1); finish_red(2); finish_red(3);
    wait_idle(20);

    // Reset with three patches outstanding
    sum_ready = 1'b0;
    request(11'd500, 32'h4400_0000, 0);
    request(11'd501, 32'h4400_0001, 1);
    request(11'd502, 32'h4400_0002, 2);
    finish_red(0);
    tick();
    check("pre_rst_valid", 64'(sum_valid), 64'(1));
    #2;
    reset           = 1'b1;
    patch_valid     = 1'b1;
    patch_start_row = 11'd7;
    #1;
    check("mid_rst_sum_valid", 64'(sum_valid), 64'(0));
    check("mid_rst_sum", 64'(sum), 64'(0));
    check("mid_rst_sum_row", 64'(sum_row), 64'(0));
    check("mid_rst_start_row", 64'(red_start_row), 64'(0));
    check("mid_rst_red_init", 64'(red_init), 64'(0));
    check("mid_rst_red_ack", 64'(red_sum_ack), 64'(0));
    check("mid_rst_patch_ack", 64'(patch_ack), 64'(0));
    exp_q.delete();
    red_sum_rdy = '0;
    tick();
    tick();
    reset       = 1'b0;
    patch_valid = 1'b0;
    sum_ready   = 1'b1;
    check("post_rst_idle", 64'(idle), 64'(1));
    tick();
    check("post_rst_no_ack", 64'(red_sum_ack), 64'(0));
    request(11'd600, 32'h4500_0000, 0);
    finish_red(0);
    wait_idle(10);

    check("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
